cart_bus_ctrl: RTL

Parametrised Atari 7800 cartridge bus front end, successor to the flat-ROM decoder in the cartridge top level. It synchronises the 6502/MARIA bus and requires the address to be stable before any read drive. It adds SuperGame-style bank switching and generates exactly one clean write strobe per bus cycle for an external register window (POKEY or similar). Buffer control, the external synchronous ROM and the audio core attach to its ports.

---
 rtl/cart_bus_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cart_bus_ctrl.sv
// Atari 7800 cartridge bus front end: synchronises the async bus, drives ROM reads once the
// address has settled, switches SuperGame banks and issues one write strobe per bus cycle.
module cart_bus_ctrl #(
  parameter int          SYNC_STAGES   = 2,
  parameter int          BANK_BITS     = 3,
  parameter int          ROM_AW        = BANK_BITS + 14,
  parameter int          SETTLE_CYCLES = 3,
  parameter logic [11:0] IO_BASE       = 12'h045,
  parameter bit          BANKSW_EN     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          a,
  input  logic [7:0]           d_in,
  input  logic                 phi2,
  input  logic                 rw,
  input  logic                 halt,
  output logic [ROM_AW-1:0]    rom_addr,
  input  logic [7:0]           rom_data,
  output logic [7:0]           d_out,
  output logic                 d_oe,
  output logic                 buf_dir,
  output logic                 buf_oe,
  output logic                 io_we,
  output logic [3:0]           io_addr,
  output logic [7:0]           io_wdata,
  output logic [BANK_BITS-1:0] bank
);

  localparam int                   NUM_BANKS = 2 ** BANK_BITS;
  localparam logic [BANK_BITS-1:0] BANK_HI   = BANK_BITS'(NUM_BANKS - 1);
  localparam logic [BANK_BITS-1:0] BANK_LO   = BANK_BITS'(NUM_BANKS - 2);
  localparam logic [3:0]           SETTLE_N  = 4'(SETTLE_CYCLES);

  typedef enum logic [2:0] {IDLE, SETTLE, FETCH, DRIVE, WR_WAIT, WR_STROBE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0][15:0] a_sync;
  logic [SYNC_STAGES-1:0][10:0] c_sync;
  logic [15:0]          a_s, a_next, a_prev;
  logic [7:0]           d_s, hold;
  logic                 phi2_s, rw_s, halt_s, phi2_d, phi2_fall;
  logic [3:0]           stab_cnt;
  logic                 stable, a_chg, a_settling;
  logic                 win, rom_hit, bank_hit, io_hit, wr_ok;
  logic [BANK_BITS-1:0] mapped_bank;
  logic                 wr_armed, wr_io, wr_bank, strobe_go;
  logic [3:0]           wr_idx;

  // Synchroniser chains (data only, no reset)
  always_ff @(posedge clk) begin
    a_sync <= {a_sync[SYNC_STAGES-2:0], a};
    c_sync <= {c_sync[SYNC_STAGES-2:0], {d_in, phi2, rw, halt}};
    a_prev <= a_s;
  end

  assign a_s                         = a_sync[SYNC_STAGES-1];
  assign a_next                      = a_sync[SYNC_STAGES-2];
  assign {d_s, phi2_s, rw_s, halt_s} = c_sync[SYNC_STAGES-1];
  assign phi2_fall                   = phi2_d & ~phi2_s;
  // Counter looks one stage ahead so it clears on the same edge a_s takes its new value.
  assign a_settling                  = (a_next != a_s);
  assign a_chg                       = (a_s != a_prev);
  assign stable                      = (stab_cnt >= SETTLE_N);
  assign win                         = (phi2_s & halt_s) | ~halt_s;

  assign rom_hit  = (a_s[15:14] != 2'b00);
  assign bank_hit = (a_s[15:14] == 2'b10);
  assign io_hit   = (a_s[15:4] == IO_BASE);
  assign wr_ok    = ~rw_s & halt_s & (io_hit | (bank_hit & BANKSW_EN));

  always_comb begin
    case (a_s[15:14])
      2'b01:   mapped_bank = BANK_LO;
      2'b10:   mapped_bank = bank;
      default: mapped_bank = BANK_HI;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (win && (rom_hit || io_hit) && (rw_s || (wr_armed && halt_s))) state_nxt = SETTLE;
      SETTLE:
        if (!win)                       state_nxt = IDLE;
        else if (stable) begin
          if (rw_s && rom_hit)          state_nxt = FETCH;
          else if (wr_ok)               state_nxt = WR_WAIT;
          else                          state_nxt = IDLE;
        end
      FETCH:                            state_nxt = DRIVE;
      DRIVE:
        if (a_chg || !rw_s || !win)     state_nxt = IDLE;
      WR_WAIT:
        // A completed phase wins over an address change seen in the same clk.
        if (phi2_fall)                  state_nxt = WR_STROBE;
        else if (!halt_s || a_chg)      state_nxt = IDLE;
      WR_STROBE:                        state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  assign strobe_go = (state == WR_WAIT) && phi2_fall;

  // Datapath registers: ROM address, write hold and latched write target
  always_ff @(posedge clk) begin
    if (state == SETTLE && state_nxt == FETCH) rom_addr <= ROM_AW'({mapped_bank, a_s[13:0]});
    if (state == WR_WAIT && phi2_s) hold <= d_s;
    if (state == SETTLE && state_nxt == WR_WAIT) begin
      wr_io   <= io_hit;
      wr_bank <= bank_hit;
      wr_idx  <= a_s[3:0];
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      stab_cnt <= 4'd0;
      phi2_d   <= 1'b0;
      wr_armed <= 1'b0;
      io_we    <= 1'b0;
      io_addr  <= 4'd0;
      io_wdata <= 8'd0;
      bank     <= '0;
    end else begin
      state    <= state_nxt;
      phi2_d   <= phi2_s;
      if (a_settling)              stab_cnt <= 4'd0;
      else if (stab_cnt != 4'hF)   stab_cnt <= stab_cnt + 4'd1;
      if (state == WR_STROBE)      wr_armed <= 1'b0;
      else if (!phi2_s)            wr_armed <= 1'b1;
      io_we <= strobe_go & wr_io;
      if (strobe_go && wr_io) begin
        io_addr  <= wr_idx;
        io_wdata <= hold;
      end
      if (strobe_go && wr_bank && BANKSW_EN) bank <= hold[BANK_BITS-1:0];
    end
  end

  assign d_oe    = (state == DRIVE);
  assign d_out   = d_oe ? rom_data : 8'd0;
  assign buf_dir = (state == DRIVE);
  assign buf_oe  = ~((state == DRIVE) | (state == WR_WAIT));

endmodule
